board_loader: RTL and testbench
===============================

Name: board_loader

Overview:
- Front-end feeder for board_attack: the producer side of the board/board_valid/is_attacking_done interface.
- Accepts a host stream of 64 square codes with a valid/ready handshake and assembles them into a BOARD_WIDTH vector.
- Issues a single board_valid pulse and holds the board stable until attack evaluation completes.
- Captures the white/black attack bitmaps and presents them to the host with a valid/ack handshake.

Parameters:
- PIECE_WIDTH, 4, bits per square code; empty square = 0 (piece encodings from vchess.vh).
- BOARD_WIDTH, 256, must equal 64*PIECE_WIDTH; elaboration error otherwise.
- TIMEOUT, 1024, max cycles in WAIT before abort; must be >= 2.

Ports:
- clk  in  1  single clock.
- reset  in  1  synchronous, active-low reset.
- sq_valid  in  1  host square valid.
- sq_ready  out  1  loader can accept a square.
- sq_piece  in  PIECE_WIDTH  square code, streamed in index order 0..63.
- sq_last  in  1  marks square 63.
- sq_white_to_move  in  1  side to move; sampled with the sq_last beat.
- board  out  BOARD_WIDTH  square i is board[i*PIECE_WIDTH +: PIECE_WIDTH].
- board_valid  out  1  one-cycle start pulse to board_attack.
- white_to_move  out  1  registered side to move; held with board.
- is_attacking_done  in  1  board_attack completion.
- white_is_attacking  in  64  from board_attack.
- black_is_attacking  in  64  from board_attack.
- res_white  out  64  captured white attack map.
- res_black  out  64  captured black attack map.
- res_valid  out  1  results available.
- res_ack  in  1  host consumed results.
- frame_error  out  1  one-cycle pulse on a framing error or timeout.
- busy  out  1  high in ISSUE, WAIT and RESULT.

Behaviour:
- Reset (reset==0 at a clk edge):
  - State = LOAD, idx = 0, timeout counter = 0.
  - board, white_to_move, res_white, res_black = 0.
  - board_valid, res_valid, frame_error, busy = 0; sq_ready = 1 from the first cycle after reset.
  - Reset mid-frame discards all partial data. No output glitches: everything is registered.
- LOAD: sq_ready = 1. A beat is accepted when sq_valid && sq_ready.
  - Accepted beat writes sq_piece into the board slot at idx; idx increments.
  - Beat with sq_last && idx==63: also latches white_to_move; next state ISSUE.
  - Beat with sq_last && idx!=63: frame_error pulses next cycle, idx resets to 0, state stays LOAD. Board contents are undefined-but-stale; the next frame overwrites them fully.
  - Beat with idx==63 && !sq_last: same error handling as above.
- ISSUE: sq_ready = 0; board_valid = 1 for exactly this one cycle; next state WAIT.
  - Latency: last beat accepted at cycle N -> board_valid high at cycle N+1.
- WAIT: board and white_to_move held stable.
  - is_attacking_done is only honoured in WAIT. A done asserted during the ISSUE cycle is treated as stale and ignored.
  - On done: res_white/res_black capture the input maps; next state RESULT. Done at cycle M -> res_valid = 1 at M+1.
  - Counter increments every WAIT cycle. On reaching TIMEOUT-1 without done: frame_error pulse, idx = 0, return to LOAD, no results captured. Done and timeout in the same cycle: done wins.
- RESULT: res_valid = 1 and results held.
  - res_ack is sampled only here. On res_ack: res_valid drops the next cycle, idx = 0, state = LOAD.
  - A res_ack outside RESULT is ignored.
  - No new squares are accepted until the ack (sq_ready = 0).
- busy = (state != LOAD).
- Widths: idx is 6 bits, so wrap is impossible because the idx==63 rule fires first. The counter is $clog2(TIMEOUT)+1 bits, saturating.

Decomposition:
- Shared package (vchess_pkg):
  - State enum (LOAD, ISSUE, WAIT, RESULT).
  - EMPTY_PIECE = 0.
  - SQUARES = 64.
  - Square-slice helper function (index -> bit offset), reused by board_attack.
- One natural sub-module: board_loader_timeout, the saturating WAIT counter with clear/enable and expired output. Everything else stays inline.

Test Plan:
- Normal frame: stream 64 beats (piece = idx mod 16, sq_last on beat 63, white_to_move = 1) at full rate, with a model returning done 5 cycles after board_valid with maps 64'h00FF and 64'hFF00.
  -> board_valid is a single pulse 1 cycle after the last beat; board slice 5 == 4'h5; res_valid 1 cycle after done with res_white == 64'h00FF and res_black == 64'hFF00; sq_ready = 0 until res_ack.
- Host backpressure: random sq_valid gaps (30% idle).
  -> Identical board contents; idx advances only on accepted beats.
- Early sq_last on beat 10 -> frame_error single pulse, no board_valid; a following clean frame completes normally.
- Missing sq_last on beat 63 -> frame_error pulse, state LOAD, idx 0; no board_valid.
- Timeout: TIMEOUT = 16, model never asserts done.
  -> frame_error 16 cycles after WAIT entry, sq_ready = 1 the next cycle, res_valid stays 0.
- Reset mid-frame after 30 beats, and separately during WAIT.
  -> All outputs return to reset values; a subsequent full frame yields correct results. A stale done pulse held high through ISSUE is not captured.

Source files
------------

// File: rtl/vchess_pkg.sv
// Shared chess-engine definitions: loader FSM states, board geometry and
// the square-to-bit-offset helper used by the loader and by board_attack.
package vchess_pkg;

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        ISSUE  = 2'd1,
        WAIT   = 2'd2,
        RESULT = 2'd3
    } state_t;

    localparam int SQUARES     = 64;
    localparam int EMPTY_PIECE = 0;
    localparam logic [5:0] LAST_SQ = 6'(SQUARES - 1);

    // Bit offset of square sq inside a packed board vector.
    function automatic int sq_offset(input int sq, input int piece_width);
        return sq * piece_width;
    endfunction

endpackage

// File: rtl/board_loader_timeout.sv
// Saturating cycle counter for the WAIT state. Cleared whenever the loader
// is not waiting; expired is high once TIMEOUT-1 has been reached.
module board_loader_timeout #(
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

    logic [CW-1:0] count;

    // Count WAIT cycles, holding at the limit instead of wrapping.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != LIMIT)) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == LIMIT);

endmodule

// File: rtl/board_loader.sv
// Host-side feeder for board_attack: assembles 64 streamed square codes into
// a packed board, fires a one-cycle board_valid, waits for the attack maps
// and hands them back to the host with a valid/ack handshake.
module board_loader
    import vchess_pkg::*;
#(
    parameter int PIECE_WIDTH = 4,
    parameter int BOARD_WIDTH = 256,
    parameter int TIMEOUT     = 1024
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   sq_valid,
    output logic                   sq_ready,
    input  logic [PIECE_WIDTH-1:0] sq_piece,
    input  logic                   sq_last,
    input  logic                   sq_white_to_move,
    output logic [BOARD_WIDTH-1:0] board,
    output logic                   board_valid,
    output logic                   white_to_move,
    input  logic                   is_attacking_done,
    input  logic [SQUARES-1:0]     white_is_attacking,
    input  logic [SQUARES-1:0]     black_is_attacking,
    output logic [SQUARES-1:0]     res_white,
    output logic [SQUARES-1:0]     res_black,
    output logic                   res_valid,
    input  logic                   res_ack,
    output logic                   frame_error,
    output logic                   busy
);

    localparam int OW = $clog2(BOARD_WIDTH);

    if (BOARD_WIDTH != SQUARES * PIECE_WIDTH) begin : g_bad_board_width
        $error("board_loader: BOARD_WIDTH must equal 64*PIECE_WIDTH");
    end
    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("board_loader: TIMEOUT must be at least 2");
    end

    state_t        state, state_next;
    logic [5:0]    idx;
    logic [OW-1:0] wr_offset;
    logic          accept;
    logic          error_next;
    logic          capture;
    logic          waiting;
    logic          timeout_expired;

    assign waiting   = (state == WAIT);
    assign wr_offset = OW'(sq_offset(int'(idx), PIECE_WIDTH));

    board_loader_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear   (!waiting),
        .enable  (waiting),
        .expired (timeout_expired)
    );

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state is always updated with <= so every flop samples pre-edge values.
        if (!reset) begin
            state <= LOAD;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode, beat acceptance, framing checks and result capture.
    always_comb begin
        // NOTE: every combinational output is defaulted first so no path can infer a latch.
        state_next = state;
        accept     = 1'b0;
        error_next = 1'b0;
        capture    = 1'b0;
        case (state)
            LOAD: begin
                accept = sq_valid && sq_ready;
                if (accept) begin
                    if (sq_last && (idx == LAST_SQ)) begin
                        state_next = ISSUE;
                    end else if (sq_last || (idx == LAST_SQ)) begin
                        error_next = 1'b1;
                    end
                end
            end
            ISSUE: begin
                // A done seen here belongs to an earlier evaluation and is ignored.
                state_next = WAIT;
            end
            WAIT: begin
                if (is_attacking_done) begin
                    capture    = 1'b1;
                    state_next = RESULT;
                end else if (timeout_expired) begin
                    error_next = 1'b1;
                    state_next = LOAD;
                end
            end
            RESULT: begin
                if (res_ack) begin
                    state_next = LOAD;
                end
            end
            default: state_next = LOAD;
        endcase
    end

    // Registered datapath and handshake outputs, all decoded from the next state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            idx           <= '0;
            // NOTE: the board is reset explicitly so a fresh loader presents an empty position.
            board         <= {SQUARES{PIECE_WIDTH'(EMPTY_PIECE)}};
            white_to_move <= 1'b0;
            res_white     <= '0;
            res_black     <= '0;
            board_valid   <= 1'b0;
            res_valid     <= 1'b0;
            frame_error   <= 1'b0;
            busy          <= 1'b0;
            sq_ready      <= 1'b1;
        end else begin
            sq_ready    <= (state_next == LOAD);
            board_valid <= (state_next == ISSUE);
            res_valid   <= (state_next == RESULT);
            busy        <= (state_next != LOAD);
            frame_error <= error_next;
            if (accept) begin
                board[wr_offset +: PIECE_WIDTH] <= sq_piece;
                // Both a completed frame and a framing error restart at square 0.
                idx <= (sq_last || (idx == LAST_SQ)) ? 6'd0 : idx + 6'd1;
                if (sq_last && (idx == LAST_SQ)) begin
                    white_to_move <= sq_white_to_move;
                end
            end
            if (capture) begin
                res_white <= white_is_attacking;
                res_black <= black_is_attacking;
            end
        end
    end

endmodule

// File: tb/tb_board_loader.sv
// Directed bench for board_loader: table-driven frames (clean, backpressured,
// early/missing sq_last) plus hand sequences for timeout, resets and stale done.
module tb_board_loader;

    localparam int PW = 4;
    localparam int BW = 256;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          sq_valid;
    logic          sq_ready;
    logic [PW-1:0] sq_piece;
    logic          sq_last;
    logic          sq_white_to_move;
    logic [BW-1:0] board;
    logic          board_valid;
    logic          white_to_move;
    logic          is_attacking_done;
    logic [63:0]   white_is_attacking;
    logic [63:0]   black_is_attacking;
    logic [63:0]   res_white;
    logic [63:0]   res_black;
    logic          res_valid;
    logic          res_ack;
    logic          frame_error;
    logic          busy;

    logic [BW-1:0] exp_board;
    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        int          last_at;   // beat carrying sq_last, -1 for none
        bit          wtm;
        int          off;       // piece = (beat + off) mod 16
        int          gap;       // percent idle cycles before each beat
        bit          exp_err;
        logic [63:0] wmap;
        logic [63:0] bmap;
        logic [3:0]  exp_s5;    // expected code in square 5
    } vec_t;

    vec_t vecs[5];

    always #5 clk = ~clk;

    board_loader #(
        .PIECE_WIDTH (PW),
        .BOARD_WIDTH (BW),
        .TIMEOUT     (TO)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .sq_valid           (sq_valid),
        .sq_ready           (sq_ready),
        .sq_piece           (sq_piece),
        .sq_last            (sq_last),
        .sq_white_to_move   (sq_white_to_move),
        .board              (board),
        .board_valid        (board_valid),
        .white_to_move      (white_to_move),
        .is_attacking_done  (is_attacking_done),
        .white_is_attacking (white_is_attacking),
        .black_is_attacking (black_is_attacking),
        .res_white          (res_white),
        .res_black          (res_black),
        .res_valid          (res_valid),
        .res_ack            (res_ack),
        .frame_error        (frame_error),
        .busy               (busy)
    );

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic stream_frame(input int nbeats, input int last_at, input bit wtm,
                                input int off, input int gap);
        for (int i = 0; i < nbeats; i++) begin
            if (gap > 0) begin
                sq_valid = 1'b0;
                while ($urandom_range(99) < gap) tick();
            end
            sq_valid         = 1'b1;
            sq_piece         = 4'((i + off) % 16);
            sq_last          = (i == last_at);
            sq_white_to_move = wtm;
            if (!sq_ready) begin
                for (int w = 0; w < 8 && !sq_ready; w++) tick();
                if (!sq_ready) check("sq_ready_wait", sq_ready, 1'b1);
            end
            exp_board[i*PW +: PW] = sq_piece;
            tick();
        end
        sq_valid = 1'b0;
        sq_last  = 1'b0;
    endtask

    // Called in the cycle after the last beat; leaves the bench in the first WAIT cycle.
    task automatic issue_checks(input bit wtm, input logic [3:0] s5);
        check("issue_board_valid", board_valid, 1'b1);
        check("issue_sq_ready", sq_ready, 1'b0);
        check("issue_busy", busy, 1'b1);
        check("issue_board", board, exp_board);
        check("issue_slice5", board[5*PW +: PW], s5);
        check("issue_wtm", white_to_move, wtm);
        tick();
        check("wait_board_valid_pulse", board_valid, 1'b0);
    endtask

    // Starts in the first WAIT cycle; done goes high 5 cycles after board_valid.
    task automatic result_seq(input logic [63:0] w, input logic [63:0] b);
        repeat (4) tick();
        check("wait_res_valid", res_valid, 1'b0);
        check("wait_board_held", board, exp_board);
        is_attacking_done  = 1'b1;
        white_is_attacking = w;
        black_is_attacking = b;
        tick();
        is_attacking_done  = 1'b0;
        white_is_attacking = ~w;
        black_is_attacking = ~b;
        check("res_valid", res_valid, 1'b1);
        check("res_white", res_white, w);
        check("res_black", res_black, b);
        check("result_sq_ready", sq_ready, 1'b0);
        repeat (2) tick();
        check("result_held_valid", res_valid, 1'b1);
        check("result_held_white", res_white, w);
        res_ack = 1'b1;
        tick();
        res_ack = 1'b0;
        check("ack_res_valid", res_valid, 1'b0);
        check("ack_sq_ready", sq_ready, 1'b1);
        check("ack_busy", busy, 1'b0);
    endtask

    task automatic error_checks();
        check("err_pulse", frame_error, 1'b1);
        check("err_board_valid", board_valid, 1'b0);
        check("err_sq_ready", sq_ready, 1'b1);
        check("err_busy", busy, 1'b0);
        tick();
        check("err_single_pulse", frame_error, 1'b0);
        check("err_no_issue", board_valid, 1'b0);
    endtask

    task automatic do_reset_and_check();
        reset = 1'b0;
        tick();
        check("rst_board", board, '0);
        check("rst_wtm", white_to_move, 1'b0);
        check("rst_res_white", res_white, '0);
        check("rst_res_black", res_black, '0);
        check("rst_board_valid", board_valid, 1'b0);
        check("rst_res_valid", res_valid, 1'b0);
        check("rst_frame_error", frame_error, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_sq_ready", sq_ready, 1'b1);
        reset     = 1'b1;
        exp_board = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int early;

        vecs[0] = '{63, 1'b1, 0, 0,  1'b0, 64'h00FF, 64'hFF00, 4'h5};
        vecs[1] = '{63, 1'b0, 7, 30, 1'b0, 64'h8000_0000_0000_0001, 64'h0123_4567_89AB_CDEF, 4'hC};
        vecs[2] = '{10, 1'b1, 3, 0,  1'b1, 64'h0, 64'h0, 4'h0};
        vecs[3] = '{-1, 1'b0, 5, 0,  1'b1, 64'h0, 64'h0, 4'h0};
        vecs[4] = '{63, 1'b1, 9, 0,  1'b0, 64'hAAAA_5555_0F0F_F0F0, 64'h1, 4'hE};

        reset              = 1'b0;
        sq_valid           = 1'b0;
        sq_piece           = '0;
        sq_last            = 1'b0;
        sq_white_to_move   = 1'b0;
        is_attacking_done  = 1'b0;
        white_is_attacking = '0;
        black_is_attacking = '0;
        res_ack            = 1'b0;
        exp_board          = '0;
        tick();
        do_reset_and_check();

        for (int v = 0; v < 5; v++) begin
            stream_frame((vecs[v].last_at >= 0) ? vecs[v].last_at + 1 : 64,
                         vecs[v].last_at, vecs[v].wtm, vecs[v].off, vecs[v].gap);
            if (vecs[v].exp_err) begin
                error_checks();
            end else begin
                issue_checks(vecs[v].wtm, vecs[v].exp_s5);
                result_seq(vecs[v].wmap, vecs[v].bmap);
            end
        end

        // Timeout: done never arrives; frame_error lands 16 cycles after WAIT entry.
        stream_frame(64, 63, 1'b1, 2, 0);
        issue_checks(1'b1, 4'h7);
        early = 0;
        for (int k = 0; k < 15; k++) begin
            tick();
            if (frame_error || res_valid) early++;
        end
        check("timeout_not_early", early, 0);
        tick();
        check("timeout_pulse", frame_error, 1'b1);
        check("timeout_no_result", res_valid, 1'b0);
        check("timeout_busy", busy, 1'b0);
        tick();
        check("timeout_sq_ready", sq_ready, 1'b1);
        check("timeout_single_pulse", frame_error, 1'b0);
        check("timeout_res_white_kept", res_white, 64'hAAAA_5555_0F0F_F0F0);

        // Reset after 30 beats, then a full frame.
        stream_frame(30, -1, 1'b1, 4, 0);
        do_reset_and_check();
        stream_frame(64, 63, 1'b0, 6, 0);
        issue_checks(1'b0, 4'hB);
        result_seq(64'h0000_FFFF_0000_FFFF, 64'hF0F0_0000_0000_0F0F);

        // Reset in WAIT, then a frame with a stale done held through ISSUE.
        stream_frame(64, 63, 1'b1, 1, 0);
        issue_checks(1'b1, 4'h6);
        tick();
        do_reset_and_check();
        is_attacking_done  = 1'b1;
        white_is_attacking = 64'hDEAD_BEEF_DEAD_BEEF;
        black_is_attacking = 64'hBAD0_BAD0_BAD0_BAD0;
        stream_frame(64, 63, 1'b1, 8, 0);
        check("stale_board_valid", board_valid, 1'b1);
        tick();
        is_attacking_done = 1'b0;
        res_ack           = 1'b1;
        tick();
        res_ack = 1'b0;
        check("stale_not_captured", res_valid, 1'b0);
        check("stale_busy", busy, 1'b1);
        check("stale_board_held", board, exp_board);
        is_attacking_done  = 1'b1;
        white_is_attacking = 64'h1234_5678_9ABC_DEF0;
        black_is_attacking = 64'h0FED_CBA9_8765_4321;
        tick();
        is_attacking_done = 1'b0;
        check("post_stale_res_valid", res_valid, 1'b1);
        check("post_stale_res_white", res_white, 64'h1234_5678_9ABC_DEF0);
        check("post_stale_res_black", res_black, 64'h0FED_CBA9_8765_4321);
        res_ack = 1'b1;
        tick();
        res_ack = 1'b0;
        check("post_stale_ack", res_valid, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
